// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: multi-cycle sequencer that decodes instruction words
// and drives ALU op, register addresses, immediate, write strobe and pc.

module alu_ctrl_fsm #(
    parameter int unsigned PC_STEP = 4,
    parameter int unsigned IMM_W   = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [2:0]  alu_op,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic [31:0] immediate,
    output logic        reg_we,
    output logic [31:0] pc,
    output logic        illegal_instr,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] ir;
    logic [31:0] pc_next;
    logic [3:0]  opcode;
    logic [2:0]  alu_map;
    logic [2:0]  alu_next;
    logic        accept;
    logic        is_alu;
    logic        is_nop;
    logic        is_halt;
    logic        ready_next;
    logic        we_next;
    logic        ill_next;
    logic        halted_next;

    assign opcode  = ir[31:28];
    assign is_alu  = (opcode >= 4'd1) && (opcode <= 4'd6);
    assign is_nop  = (opcode == 4'd0);
    assign is_halt = (opcode == 4'd7);
    assign accept  = (state == S_FETCH) && instr_valid && instr_ready;

    // Operand fields come straight from the latched word, so they are
    // stable from DECODE until the next accepted instruction.
    assign rd_addr   = ir[27:23];
    assign rs1_addr  = ir[22:18];
    assign rs2_addr  = ir[17:13];
    assign immediate = {{(32-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};

    // Opcode to ALU operation code.
    always_comb begin
        alu_map = 3'b000;
        case (opcode)
            4'd1:    alu_map = 3'b010;
            4'd2:    alu_map = 3'b011;
            4'd3:    alu_map = 3'b100;
            4'd4:    alu_map = 3'b101;
            4'd5:    alu_map = 3'b110;
            4'd6:    alu_map = 3'b111;
            default: alu_map = 3'b000;
        endcase
    end

    // Next state plus next values of the registered outputs.
    always_comb begin
        next_state = state;
        pc_next    = pc;
        ill_next   = 1'b0;
        case (state)
            S_FETCH: begin
                if (accept) next_state = S_DECODE;
            end
            S_DECODE: begin
                unique case (1'b1)
                    is_alu: next_state = S_EXEC;
                    is_nop: begin
                        pc_next    = pc + PC_STEP;
                        next_state = S_FETCH;
                    end
                    is_halt: next_state = S_HALT;
                    default: begin
                        ill_next   = 1'b1;
                        pc_next    = pc + PC_STEP;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_EXEC: next_state = S_WB;
            S_WB: begin
                pc_next    = pc + PC_STEP;
                next_state = S_FETCH;
            end
            S_HALT:  next_state = S_HALT;
            default: next_state = S_FETCH;
        endcase
        ready_next  = (next_state == S_FETCH);
        halted_next = (next_state == S_HALT);
        we_next     = (next_state == S_WB) && (ir[27:23] != 5'd0);
        alu_next    = ((next_state == S_EXEC) || (next_state == S_WB))
                      ? alu_map : 3'b000;
    end

    // State, instruction register and all Moore outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_FETCH;
            ir            <= '0;
            pc            <= '0;
            instr_ready   <= 1'b0;
            alu_op        <= 3'b000;
            reg_we        <= 1'b0;
            illegal_instr <= 1'b0;
            halted        <= 1'b0;
        end else begin
            state         <= next_state;
            if (accept) ir <= instr;
            pc            <= pc_next;
            instr_ready   <= ready_next;
            alu_op        <= alu_next;
            reg_we        <= we_next;
            illegal_instr <= ill_next;
            halted        <= halted_next;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb_alu_ctrl_fsm: randomized stimulus with a scoreboard of expected
// retirements, checked by an independent output monitor.

module tb_alu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [2:0]  alu_op;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] immediate;
    logic        reg_we;
    logic [31:0] pc;
    logic        illegal_instr;
    logic        halted;

    alu_ctrl_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .alu_op        (alu_op),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rd_addr       (rd_addr),
        .immediate     (immediate),
        .reg_we        (reg_we),
        .pc            (pc),
        .illegal_instr (illegal_instr),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          busy;
        int          we;
        int          ill;
        int          alu_n;
        logic [2:0]  alu;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        halt;
    } exp_t;

    exp_t        sbq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] pc_model;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op,
                                       input logic [4:0] rd,
                                       input logic [4:0] rs1,
                                       input logic [4:0] rs2,
                                       input logic [12:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    // Reference: what one instruction should do, from the ISA rules.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        int op;
        int v;
        op = int'(w[31:28]);
        v  = int'(w[12:0]);
        if (v >= 4096) v = v - 8192;
        e.imm   = 32'(v);
        e.rd    = w[27:23];
        e.rs1   = w[22:18];
        e.rs2   = w[17:13];
        e.busy  = 1;
        e.we    = 0;
        e.ill   = 0;
        e.alu_n = 0;
        e.alu   = 3'd0;
        e.halt  = 1'b0;
        if (op >= 1 && op <= 6) begin
            e.busy  = 3;
            e.alu_n = 2;
            e.alu   = 3'(op + 1);
            e.we    = (w[27:23] != 0) ? 1 : 0;
            pc_model = pc_model + 32'd4;
        end else if (op == 7) begin
            e.halt = 1'b1;
        end else begin
            e.ill = (op >= 8) ? 1 : 0;
            pc_model = pc_model + 32'd4;
        end
        e.pc = pc_model;
        return e;
    endfunction

    // Monitor: a retirement window opens when instr_ready falls and
    // closes when it rises again (or halted rises).
    logic       prev_ready;
    bit         open;
    int         m_busy, m_we, m_ill, m_alu_n;
    logic [2:0] m_alu;

    initial begin
        exp_t e;
        prev_ready = 1'b0;
        open       = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                open       = 1'b0;
                prev_ready = 1'b0;
                sbq.delete();
            end else begin
                if (prev_ready && !instr_ready) begin
                    open    = 1'b1;
                    m_busy  = 0;
                    m_we    = 0;
                    m_ill   = 0;
                    m_alu_n = 0;
                    m_alu   = 3'd0;
                end
                if (open) begin
                    if (reg_we) m_we++;
                    if (illegal_instr) m_ill++;
                    if (alu_op != 3'd0) begin
                        m_alu_n++;
                        m_alu = alu_op;
                    end
                    if (!instr_ready && !halted) m_busy++;
                    if (instr_ready || halted) begin
                        open = 1'b0;
                        if (sbq.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL sb_empty: retire, pc %h", pc);
                        end else begin
                            e = sbq.pop_front();
                            chk("busy_cycles", m_busy, e.busy);
                            chk("reg_we_pulses", m_we, e.we);
                            chk("illegal_pulses", m_ill, e.ill);
                            chk("alu_cycles", m_alu_n, e.alu_n);
                            chk("alu_op", m_alu, e.alu);
                            chk("pc", pc, e.pc);
                            chk("rd_addr", rd_addr, e.rd);
                            chk("rs1_addr", rs1_addr, e.rs1);
                            chk("rs2_addr", rs2_addr, e.rs2);
                            chk("immediate", immediate, e.imm);
                            chk("halted", halted, e.halt);
                        end
                    end
                end else if (reg_we || illegal_instr) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stray_pulse: we %b ill %b at %0t",
                             reg_we, illegal_instr, $time);
                end
                prev_ready = instr_ready;
            end
        end
    end

    task automatic issue(input logic [31:0] w);
        int guard;
        int gap;
        guard = 0;
        gap   = $urandom_range(0, 2);
        forever begin
            @(negedge clk);
            if (instr_ready && gap == 0) break;
            if (instr_ready) begin
                instr_valid = 1'b0;
                gap--;
            end else begin
                instr_valid = 1'($urandom_range(0, 1));
                instr       = $urandom;
            end
            guard++;
            if (guard > 100) begin
                n_tests++;
                n_fail++;
                $display("FAIL issue_timeout: ready %b", instr_ready);
                return;
            end
        end
        instr       = w;
        instr_valid = 1'b1;
        sbq.push_back(model(w));
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (instr_ready) return;
            @(negedge clk);
        end
        n_tests++;
        n_fail++;
        $display("FAIL idle_timeout: ready %b", instr_ready);
    endtask

    initial begin
        logic [3:0] op;
        bit         seen;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        pc_model    = '0;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_ready", {31'd0, instr_ready}, 32'd0);
        chk("rst_alu", {29'd0, alu_op}, 32'd0);
        chk("rst_imm", immediate, 32'h0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_first_edge", {31'd0, instr_ready}, 32'd1);

        issue(mk(4'd1, 5'd3, 5'd1, 5'd2, 13'd0));
        issue(mk(4'd5, 5'd5, 5'd1, 5'd0, 13'h1FFF));
        issue(mk(4'd6, 5'd5, 5'd1, 5'd0, 13'h0005));
        issue(mk(4'd1, 5'd0, 5'd1, 5'd2, 13'd0));
        issue(mk(4'hA, 5'd9, 5'd2, 5'd3, 13'h0123));
        issue(mk(4'd0, 5'd4, 5'd4, 5'd4, 13'h1000));

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd7) op = 4'd0;
            issue({op, 28'($urandom)});
        end

        wait_idle();
        force dut.pc = 32'hFFFFFFFC;
        @(negedge clk);
        release dut.pc;
        pc_model = 32'hFFFFFFFC;
        issue(mk(4'd3, 5'd7, 5'd1, 5'd2, 13'd0));
        wait_idle();
        chk("pc_wrap", pc, 32'h0);

        issue(mk(4'd4, 5'd6, 5'd1, 5'd2, 13'd0));
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (alu_op != 3'd0) seen = 1'b1;
            else @(negedge clk);
        end
        chk("exec_reached", {31'd0, seen}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_alu", {29'd0, alu_op}, 32'd0);
        chk("async_pc", pc, 32'h0);
        chk("async_rd", {27'd0, rd_addr}, 32'd0);
        chk("async_ready", {31'd0, instr_ready}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_no_we", {31'd0, reg_we}, 32'd0);
        end
        pc_model = '0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("post_rst_pc", pc, 32'h0);
        chk("post_rst_no_we", {31'd0, reg_we}, 32'd0);

        issue(mk(4'd2, 5'd8, 5'd3, 5'd4, 13'h1F00));
        issue(mk(4'd7, 5'd0, 5'd0, 5'd0, 13'd0));
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (halted) seen = 1'b1;
            else @(negedge clk);
        end
        chk("halt_reached", {31'd0, seen}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            instr_valid = 1'b1;
            instr       = $urandom;
            @(negedge clk);
            chk("halt_ready", {31'd0, instr_ready}, 32'd0);
            chk("halt_flag", {31'd0, halted}, 32'd1);
            chk("halt_pc", pc, pc_model);
        end
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_drain", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
